// File: rtl/d_reg_shift_asyn_rstn.sv
// WIDTH-bit register with load/shift/rotate/clear modes, complementary outputs,
// saturating shift counter and a one-cycle done pulse; async active-low reset.
module d_reg_shift_asyn_rstn #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           D,
    input  logic                       sin,
    output logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           Qn,
    output logic                       sout,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_ROTL  = 3'b100,
        M_ROTR  = 3'b101,
        M_CLEAR = 3'b110,
        M_RSVD  = 3'b111
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             shifting;

    assign op = mode_e'(mode);

    always_comb begin
        q_nxt    = Q;
        cnt_nxt  = shift_cnt;
        done_nxt = 1'b0;
        shifting = 1'b0;
        if (en) begin
            unique case (op)
                M_HOLD:  q_nxt = Q;
                M_LOAD: begin
                    q_nxt   = D;
                    cnt_nxt = '0;
                end
                M_SHL: begin
                    q_nxt    = {Q[WIDTH-2:0], sin};
                    shifting = 1'b1;
                end
                M_SHR: begin
                    q_nxt    = {sin, Q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                M_ROTL: begin
                    q_nxt    = {Q[WIDTH-2:0], Q[WIDTH-1]};
                    shifting = 1'b1;
                end
                M_ROTR: begin
                    q_nxt    = {Q[0], Q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                M_CLEAR: begin
                    q_nxt   = RESET_VAL;
                    cnt_nxt = '0;
                end
                M_RSVD:  q_nxt = Q;
            endcase
        end
        // Count saturates; done fires only on the WIDTH-1 -> WIDTH step
        if (shifting && (shift_cnt != CNT_MAX)) begin
            cnt_nxt  = shift_cnt + 1'b1;
            done_nxt = (shift_cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q         <= RESET_VAL;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            Q         <= q_nxt;
            shift_cnt <= cnt_nxt;
            done      <= done_nxt;
        end
    end

    assign Qn   = ~Q;
    assign sout = ((op == M_SHL) || (op == M_ROTL)) ? Q[WIDTH-1] : Q[0];

endmodule

// File: tb/tb_d_reg_shift_asyn_rstn.sv
// Bench for d_reg_shift_asyn_rstn at WIDTH 8, 2 and 64 against a
// behavioural register/counter model plus directed literal checks.
module tb_d_reg_shift_asyn_rstn;

    localparam logic [7:0]  RV8  = 8'hA5;
    localparam logic [1:0]  RV2  = 2'b01;
    localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        reset_n, en, sin;
    logic [2:0]  mode;
    logic [7:0]  d8;
    logic [1:0]  d2;
    logic [63:0] d64;

    logic [7:0]  q8, qn8;
    logic [1:0]  q2, qn2;
    logic [63:0] q64, qn64;
    logic        sout8, sout2, sout64;
    logic        done8, done2, done64;
    logic [3:0]  cnt8;
    logic [1:0]  cnt2;
    logic [6:0]  cnt64;

    always #5 clk = ~clk;

    d_reg_shift_asyn_rstn #(.WIDTH(8), .RESET_VAL(RV8)) u8 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .D(d8),
        .sin(sin), .Q(q8), .Qn(qn8), .sout(sout8), .shift_cnt(cnt8),
        .done(done8)
    );
    d_reg_shift_asyn_rstn #(.WIDTH(2), .RESET_VAL(RV2)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .D(d2),
        .sin(sin), .Q(q2), .Qn(qn2), .sout(sout2), .shift_cnt(cnt2),
        .done(done2)
    );
    d_reg_shift_asyn_rstn #(.WIDTH(64), .RESET_VAL(RV64)) u64 (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .D(d64),
        .sin(sin), .Q(q64), .Qn(qn64), .sout(sout64), .shift_cnt(cnt64),
        .done(done64)
    );

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    // Behavioural model: one entry per instance (8, 2, 64)
    int          wd[3]  = '{8, 2, 64};
    logic [63:0] rvs[3] = '{64'hA5, 64'h1, RV64};
    logic [63:0] mq[3];
    int          mc[3];
    bit          md[3];

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] din(input int i);
        case (i)
            0:       return {56'd0, d8};
            1:       return {62'd0, d2};
            default: return d64;
        endcase
    endfunction

    function automatic logic msout(input int i);
        if (mode == 3'd2 || mode == 3'd4) return mq[i][wd[i]-1];
        return mq[i][0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = rvs[i];
            mc[i] = 0;
            md[i] = 1'b0;
        end
    endtask

    task automatic model_next(output logic [63:0] nq[3], output int nc[3],
                              output bit nd[3]);
        for (int i = 0; i < 3; i++) begin
            int w;
            logic [63:0] q;
            w     = wd[i];
            q     = mq[i];
            nq[i] = q;
            nc[i] = mc[i];
            nd[i] = 1'b0;
            if (en) begin
                case (mode)
                    3'd1: begin nq[i] = din(i) & msk(w); nc[i] = 0; end
                    3'd2: nq[i] = ((q << 1) | 64'(sin)) & msk(w);
                    3'd3: nq[i] = (q >> 1) | (64'(sin) << (w - 1));
                    3'd4: nq[i] = ((q << 1) | (q >> (w - 1))) & msk(w);
                    3'd5: nq[i] = (q >> 1) | ((q & 64'd1) << (w - 1));
                    3'd6: begin nq[i] = rvs[i]; nc[i] = 0; end
                    default: ;
                endcase
                if (mode inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
                    nc[i] = (mc[i] < w) ? mc[i] + 1 : w;
                    nd[i] = (mc[i] == w - 1);
                end
            end
        end
    endtask

    task automatic op(input logic e, input logic [2:0] m, input logic s,
                      input logic [63:0] d);
        logic [63:0] nq[3];
        int nc[3];
        bit nd[3];
        en   = e;
        mode = m;
        sin  = s;
        d8   = d[7:0];
        d2   = d[1:0];
        d64  = d;
        model_next(nq, nc, nd);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = nq[i];
            mc[i] = nc[i];
            md[i] = nd[i];
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("q8",     64'(q8),     mq[0]);
            chk("qn8",    64'(qn8),    ~mq[0] & msk(8));
            chk("sout8",  64'(sout8),  64'(msout(0)));
            chk("cnt8",   64'(cnt8),   64'(mc[0]));
            chk("done8",  64'(done8),  64'(md[0]));
            chk("q2",     64'(q2),     mq[1]);
            chk("qn2",    64'(qn2),    ~mq[1] & msk(2));
            chk("sout2",  64'(sout2),  64'(msout(1)));
            chk("cnt2",   64'(cnt2),   64'(mc[1]));
            chk("done2",  64'(done2),  64'(md[1]));
            chk("q64",    q64,         mq[2]);
            chk("qn64",   qn64,        ~mq[2]);
            chk("sout64", 64'(sout64), 64'(msout(2)));
            chk("cnt64",  64'(cnt64),  64'(mc[2]));
            chk("done64", 64'(done64), 64'(md[2]));
        end
    end

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        mode    = 3'd0;
        sin     = 1'b0;
        d8      = '0;
        d2      = '0;
        d64     = '0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_q8",    64'(q8),    64'hA5);
        chk("rst_qn8",   64'(qn8),   64'h5A);
        chk("rst_cnt8",  64'(cnt8),  64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_q2",    64'(q2),    64'h1);
        chk("rst_q64",   q64,        RV64);
        go = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // LOAD then SHL with sin=1
        op(1'b1, 3'd1, 1'b0, 64'h0123_4567_89AB_CDC3);
        en   = 1'b1;
        mode = 3'd2;
        sin  = 1'b1;
        #1;
        chk("shl_sout_pre", 64'(sout8), 64'd1);
        op(1'b1, 3'd2, 1'b1, 64'd0);
        chk("shl_q8",  64'(q8),  64'h87);
        chk("shl_qn8", 64'(qn8), 64'h78);

        // Full ROTR cycle and saturation
        op(1'b1, 3'd1, 1'b0, 64'h8000_0000_0000_0081);
        for (int k = 1; k <= 8; k++) begin
            op(1'b1, 3'd5, 1'b0, 64'd0);
            chk("rotr_cnt8",  64'(cnt8),  64'(k));
            chk("rotr_done8", 64'(done8), 64'(k == 8));
        end
        chk("rotr_q8", 64'(q8), 64'h81);
        op(1'b1, 3'd5, 1'b0, 64'd0);
        chk("sat_cnt8",  64'(cnt8),  64'd8);
        chk("sat_done8", 64'(done8), 64'd0);

        // SHR with en toggling
        op(1'b1, 3'd1, 1'b0, 64'hF0);
        op(1'b1, 3'd3, 1'b0, 64'd0);
        chk("shr1_q8", 64'(q8), 64'h78);
        op(1'b0, 3'd3, 1'b0, 64'd0);
        chk("shr_hold_q8", 64'(q8), 64'h78);
        op(1'b1, 3'd3, 1'b0, 64'd0);
        chk("shr2_q8",   64'(q8),   64'h3C);
        chk("shr2_cnt8", 64'(cnt8), 64'd2);

        // CLEAR at count WIDTH-1, then reserved mode
        op(1'b1, 3'd1, 1'b0, 64'h5A);
        repeat (7) op(1'b1, 3'd2, 1'b1, 64'd0);
        chk("pre_clr_cnt8", 64'(cnt8), 64'd7);
        op(1'b1, 3'd6, 1'b0, 64'd0);
        chk("clr_q8",    64'(q8),    64'hA5);
        chk("clr_cnt8",  64'(cnt8),  64'd0);
        chk("clr_done8", 64'(done8), 64'd0);
        op(1'b1, 3'd7, 1'b1, 64'd0);
        chk("rsvd_q8",    64'(q8),    64'hA5);
        chk("rsvd_done8", 64'(done8), 64'd0);
        op(1'b1, 3'd1, 1'b0, 64'h3C);
        op(1'b1, 3'd7, 1'b1, 64'hFF);
        chk("rsvd_hold_q8", 64'(q8), 64'h3C);

        // Async reset mid-shift, then full runs at all widths
        op(1'b1, 3'd1, 1'b0, 64'hFF00_FF00_FF00_FF00);
        repeat (5) op(1'b1, 3'd4, 1'b0, 64'd0);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_q8",   64'(q8),   64'hA5);
        chk("mid_rst_cnt8", 64'(cnt8), 64'd0);
        chk("mid_rst_q2",   64'(q2),   64'h1);
        chk("mid_rst_q64",  q64,       RV64);
        reset_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            op(1'b1, 3'd4, 1'b0, 64'd0);
            chk("run_done8",  64'(done8),  64'(k == 8));
            chk("run_done2",  64'(done2),  64'(k == 2));
            chk("run_done64", 64'(done64), 64'(k == 64));
            chk("run_cnt64",  64'(cnt64),  64'(k));
        end
        chk("run_q64", q64, RV64);
        op(1'b0, 3'd0, 1'b0, 64'd0);
        op(1'b0, 3'd0, 1'b0, 64'd0);
        go = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_reg_shift_asyn_rstn.md
Name: d_reg_shift_asyn_rstn

Overview:
- Parametrised successor to the single-bit latch primitive: an edge-triggered WIDTH-bit register with complementary outputs and an asynchronous active-low reset.
- Adds mode-controlled load, shift, rotate and synchronous clear.
- Adds a shift counter and a done pulse, so the block can serve as a parallel-load serialiser or a deserialiser.
- Sits in the storage-primitive layer beneath the datapath blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, all zeros (WIDTH bits), value loaded into Q by reset and by the CLEAR mode.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  when 0, the register, counter and done hold; mode is ignored.
- mode  input  3  operation select (encodings in Behaviour).
- D  input  WIDTH  parallel load data.
- sin  input  1  serial input for SHL and SHR.
- Q  output  WIDTH  register contents.
- Qn  output  WIDTH  bitwise complement of Q.
- sout  output  1  serial output.
- shift_cnt  output  $clog2(WIDTH+1)  number of shift/rotate operations since the last LOAD, CLEAR or reset; saturates.
- done  output  1  one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Reset:
  - reset_n low forces, immediately and without waiting for clk: Q=RESET_VAL, Qn=~RESET_VAL, shift_cnt=0, done=0.
  - Reset dominates all other inputs.
  - Deassertion takes effect at the first rising clk edge after reset_n goes high.
- Qn is always the exact bitwise complement of Q; it is never derived independently.
- All state updates occur on the rising edge of clk when en=1. Latency is one cycle, and Q shows the new value after the edge.
- Mode encodings, applied when en=1:
  - 000 HOLD: Q unchanged; counter unchanged.
  - 001 LOAD: Q<=D; shift_cnt<=0.
  - 010 SHL: Q<={Q[WIDTH-2:0],sin}.
  - 011 SHR: Q<={sin,Q[WIDTH-1:1]}.
  - 100 ROTL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 ROTR: Q<={Q[0],Q[WIDTH-1:1]}.
  - 110 CLEAR: Q<=RESET_VAL; shift_cnt<=0.
  - 111 reserved: behaves as HOLD.
- sout is combinational from the current Q and mode:
  - Q[WIDTH-1] when mode is SHL or ROTL.
  - Q[0] in every other mode, including when en=0.
  - sout is therefore the bit that the next SHL/ROTL or SHR/ROTR edge shifts out.
- Counter:
  - Each SHL, SHR, ROTL or ROTR edge increments shift_cnt by 1, saturating at WIDTH.
  - In saturation, further shifts still modify Q, but shift_cnt stays at WIDTH.
- done:
  - Registered output.
  - Asserted for exactly the one cycle following the edge on which shift_cnt goes from WIDTH-1 to WIDTH.
  - Deasserted otherwise, including during saturation.
- en=0 forces done to 0 on the next edge.
- LOAD or CLEAR issued while shift_cnt=WIDTH-1 resets the counter, and no done pulse occurs.
- Asynchronous reset asserted mid-shift discards the partial count; done is not generated.
- No X propagation from the reserved mode; all paths assign defined values.

Test Plan:
- Reset with WIDTH=8, RESET_VAL=8'hA5; assert reset_n=0 between clock edges -> Q=8'hA5 and Qn=8'h5A immediately, shift_cnt=0, done=0.
- LOAD D=8'hC3, then SHL with sin=1 -> Q=8'h87, Qn=8'h78, sout=1 before the edge (sampling Q[7]=1).
- LOAD 8'h81, then 8 consecutive ROTR -> Q returns to 8'h81; shift_cnt goes 1..8; done=1 only in the cycle after the 8th edge; a 9th ROTR leaves shift_cnt=8 and done=0.
- LOAD 8'hF0, then SHR with sin=0, with en toggled 1,0,1 -> Q=8'h78 then holds 8'h78, then 8'h3C; shift_cnt=2.
- After 7 SHL edges, issue CLEAR -> Q=RESET_VAL and shift_cnt=0; no done pulse; mode=111 afterwards holds Q.
- Assert reset_n low after 5 shifts -> Q=RESET_VAL immediately, shift_cnt=0; after release, 8 shifts are needed before done. Repeat at WIDTH=2 and WIDTH=64 for boundary widths.
